vm2_intc: RTL and testbench

- Vectored interrupt arbiter for the MC1201.02 processor module.
- Sits directly upstream of the CPU's virq / ivec / istb / iack pins.
- Collects level interrupt requests from up to NCHAN peripherals and selects the highest-priority one.
- Runs the VM2 vector-fetch handshake and pulses a per-channel acknowledge so the selected device clears its request.

---
 rtl/vm2_intc.sv | 77 +++++++
 tb/tb_vm2_intc.sv | 118 +++++++++++
 2 files changed

// File: rtl/vm2_intc.sv
// vm2_intc: fixed-priority vectored interrupt arbiter running the VM2 virq/istb/iack vector-fetch handshake
module vm2_intc #(
  parameter int NCHAN = 8,
  parameter logic [NCHAN*16-1:0] VECTORS = '0,
  parameter logic [15:0] SPURIOUS_VEC = 16'o0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NCHAN-1:0] irq_i,
  output logic [NCHAN-1:0] irq_ack_o,
  output logic             virq,
  input  logic             istb,
  output logic [15:0]      ivec,
  output logic             iack,
  output logic             busy
);
  localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;
  state_t state;
  logic [CW-1:0] ch, win;
  always_comb begin
    win = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (irq_i[i]) win = CW'(i);
  end
  // The ack pulse and vector are loaded on ACK entry, so the pulse lasts exactly the first ACK cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      ch <= '0;
      virq <= 1'b0;
      iack <= 1'b0;
      ivec <= '0;
      irq_ack_o <= '0;
      busy <= 1'b0;
    end else begin
      irq_ack_o <= '0;
      case (state)
        IDLE:
          if (istb) begin
            state <= ACK;
            iack <= 1'b1;
            ivec <= SPURIOUS_VEC;
            busy <= 1'b1;
          end else if (|irq_i) begin
            state <= REQ;
            ch <= win;
            virq <= 1'b1;
            busy <= 1'b1;
          end
        REQ:
          if (istb) begin
            state <= ACK;
            virq <= 1'b0;
            iack <= 1'b1;
            ivec <= VECTORS[16*ch +: 16];
            irq_ack_o <= NCHAN'(1) << ch;
          end else if (!(|irq_i)) begin
            state <= IDLE;
            virq <= 1'b0;
            busy <= 1'b0;
          end else
            ch <= win;
        ACK:
          if (!istb) begin
            state <= GAP;
            iack <= 1'b0;
            ivec <= '0;
          end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vm2_intc.sv
// tb_vm2_intc: directed vector table plus back-to-back latency sequence for vm2_intc
module tb_vm2_intc;
  localparam logic [127:0] VT = {16'o300, 16'o274, 16'o270, 16'o200, 16'o60, 16'o70, 16'o64, 16'o100};
  logic clk = 0, rst = 1, istb = 0, virq, iack, busy;
  logic [7:0] irq = 0, ack;
  logic [15:0] ivec;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  vm2_intc #(.NCHAN(8), .VECTORS(VT), .SPURIOUS_VEC(16'o0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .irq_i(irq), .irq_ack_o(ack),
    .virq(virq), .istb(istb), .ivec(ivec), .iack(iack), .busy(busy)
  );
  typedef struct packed {
    logic r; logic [7:0] q; logic s;
    logic v; logic a; logic [15:0] iv; logic [7:0] k; logic b;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic r, logic [7:0] q, logic s, logic v, logic a,
                              logic [15:0] iv, logic [7:0] k, logic b);
    return '{r, q, s, v, a, iv, k, b};
  endfunction
  always @(negedge clk) if (!rst) begin
    checks++;
    if ((!iack && ivec != 0) || (virq && iack) || !$onehot0(ack)) begin
      failures++;
      $display("FAIL invariant t=%0t virq=%b iack=%b ivec=%o ack=%b", $time, virq, iack, ivec, ack);
    end
  end
  initial begin
    int n;
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h08, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h08, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h08, 1, 0, 1, 16'o60,  8'h08, 1));
    tbl.push_back(mk(0, 8'h08, 1, 0, 1, 16'o60,  8'h00, 1));
    tbl.push_back(mk(0, 8'h08, 1, 0, 1, 16'o60,  8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h80, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h82, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h82, 1, 0, 1, 16'o64,  8'h02, 1));
    tbl.push_back(mk(0, 8'h80, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h80, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h80, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h80, 1, 0, 1, 16'o300, 8'h80, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h16, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h16, 1, 0, 1, 16'o64,  8'h02, 1));
    tbl.push_back(mk(0, 8'h14, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h14, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h14, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h14, 1, 0, 1, 16'o70,  8'h04, 1));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h10, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h10, 1, 0, 1, 16'o200, 8'h10, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h20, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h01, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 16'o100, 8'h01, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h08, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h08, 1, 0, 1, 16'o60,  8'h08, 1));
    tbl.push_back(mk(1, 8'h08, 1, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h08, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h08, 1, 0, 1, 16'o60,  8'h08, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h04, 1, 0, 1, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 16'o0,   8'h00, 0));
    tbl.push_back(mk(0, 8'h04, 0, 1, 0, 16'o0,   8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 16'o0,   8'h00, 0));
    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].r; irq = tbl[i].q; istb = tbl[i].s;
      @(negedge clk);
      checks++;
      if ({virq, iack, ivec, ack, busy} !== {tbl[i].v, tbl[i].a, tbl[i].iv, tbl[i].k, tbl[i].b}) begin
        failures++;
        $display("FAIL row%0d got virq=%b iack=%b ivec=%o ack=%b busy=%b want virq=%b iack=%b ivec=%o ack=%b busy=%b",
                 i, virq, iack, ivec, ack, busy, tbl[i].v, tbl[i].a, tbl[i].iv, tbl[i].k, tbl[i].b);
      end
    end
    // Request held past its ack re-interrupts after GAP plus the IDLE->REQ edge.
    irq = 8'h02;
    n = 0;
    while (!virq && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n != 1) begin failures++; $display("FAIL first_virq_latency got=%0d want=1", n); end
    istb = 1;
    @(negedge clk);
    checks++;
    if (!iack || ivec != 16'o64 || ack != 8'h02) begin
      failures++; $display("FAIL b2b_ack got iack=%b ivec=%o ack=%b want 1 64 00000010", iack, ivec, ack);
    end
    istb = 0;
    @(negedge clk);
    n = 0;
    while (!virq && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin failures++; $display("FAIL b2b_gap got=%0d want=2", n); end
    irq = 0;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
